player_vertical_ctrl: RTL and testbench
=======================================

PLAYER_VERTICAL_CTRL -- requirements
Module: player_vertical_ctrl

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port frame_in, input, 1 bit: one-cycle physics-tick pulse, once per video frame.
REQ-004 SHALL have port speed_in, input, 4 bits: game speed code (1/2/4/8); other codes behave as 1.
REQ-005 SHALL have port jump_in, input, 1 bit: one-cycle jump request pulse, any cycle.
REQ-006 SHALL have port duck_in, input, 1 bit: one-cycle duck request pulse, any cycle.
REQ-007 SHALL have port height_out, output, 10 bits: player height in pixels = height_acc[15:6].
REQ-008 SHALL have port state_out, output, 2 bits: GROUND=0, AIR=1, DUCK=2.
REQ-009 SHALL have port ducking_out, output, 1 bit: high iff state is DUCK.
REQ-010 SHALL have port airborne_out, output, 1 bit: high iff state is AIR.

Function
REQ-011 SHALL hold internal height_acc (16-bit unsigned), vel (12-bit signed), duck_cnt (8-bit), latched gravity/duck_limit/vertical_jump, jump_pend, duck_pend, duck_on_land.
REQ-012 SHALL set jump_pend on jump_in and duck_pend on duck_in; a pulse coincident with frame_in SHALL be consumed by that frame; both pend flags clear on every frame_in.
REQ-013 SHALL change state, height_acc, vel and duck_cnt only on frame_in cycles; all outputs registered, visible the cycle after frame_in.
REQ-014 GROUND: jump pending -> AIR, vel=vertical_jump, height_acc=0; else duck pending -> DUCK, duck_cnt=0; jump wins when both pending.
REQ-015 AIR update: next = height_acc + vel in 18-bit signed; if vel<0 and next<=0 then land (height_acc=0, vel=0); else height_acc=next, vel=vel-gravity.
REQ-016 Landing SHALL go to DUCK (duck_cnt=0, duck_on_land cleared) if duck_on_land set, else GROUND.
REQ-017 AIR with duck pending SHALL set vel=-vertical_jump (slam) and set duck_on_land, applied instead of the gravity decrement that frame; height still advances by old vel.
REQ-018 AIR SHALL discard jump pending (no double jump).
REQ-019 DUCK: jump pending -> AIR exactly as REQ-014 (cancels duck); else duck pending -> duck_cnt=0 (restart); else if duck_cnt==duck_limit-1 -> GROUND; else duck_cnt+1.
REQ-020 SHALL latch gravity, duck_limit, vertical_jump from speed_in only when entering AIR from GROUND/DUCK or entering DUCK from GROUND; speed_in changes mid-action SHALL NOT affect the action in progress.
REQ-021 Parameter map: speed 1 -> (g 1, duck 128, jump 180); 2 -> (4, 64, 300); 4 -> (15, 32, 470); 8 -> (60, 16, 700); others as 1.
REQ-022 height_acc SHALL never wrap; peak at speed 1 (16290) fits 16 bits.

Reset
REQ-023 On rst_in: state GROUND, height_acc 0, vel 0, duck_cnt 0, all pend flags 0, latched params = speed-1 values; height_out 0, state_out 0, ducking_out 0, airborne_out 0.
REQ-024 Reset mid-jump or mid-duck SHALL take effect next edge regardless of frame_in; a jump_in/duck_in coincident with rst_in SHALL be dropped.

Structure
REQ-025 Shared package SHALL hold the state enum (GROUND/AIR/DUCK) and the height shift constant (6).
REQ-026 SHALL instantiate the existing speed_params block as its single sub-module for the parameter map.

Verification
REQ-027 speed 8, jump_in then frames: after update 2 height_acc=700 (height_out 10); peak 4440 (69) after update 13; lands (GROUND, height 0) on update 26 counted from start frame.
REQ-028 speed 4, duck_in: ducking_out high for exactly 32 frame intervals, then GROUND.
REQ-029 speed 8 jump, duck_in at update 5: vel becomes -700, DUCK entered on landing, ducking_out lasts 16 frames.
REQ-030 jump_in and duck_in same cycle in GROUND -> AIR; jump_in while AIR -> ignored, landing frame unchanged.
REQ-031 speed_in 1 -> 8 mid-jump: trajectory continues with g=1, vel 180 until landing; next jump uses 700/60.
REQ-032 rst_in asserted during AIR: next cycle height_out 0, state_out 0, airborne_out 0.

Source files
------------

// File: rtl/player_vertical_ctrl_pkg.sv
// player_vertical_ctrl_pkg: shared state encoding, height scaling and speed parameter sets
package player_vertical_ctrl_pkg;
    typedef enum logic [1:0] {GROUND = 2'd0, AIR = 2'd1, DUCK = 2'd2} state_t;
    localparam int HEIGHT_SHIFT = 6;
    typedef struct packed {
        logic [5:0] grav;
        logic [7:0] duck_lim;
        logic [9:0] vjump;
    } speed_cfg_t;
    localparam speed_cfg_t CFG_1 = '{grav: 6'd1,  duck_lim: 8'd128, vjump: 10'd180};
    localparam speed_cfg_t CFG_2 = '{grav: 6'd4,  duck_lim: 8'd64,  vjump: 10'd300};
    localparam speed_cfg_t CFG_4 = '{grav: 6'd15, duck_lim: 8'd32,  vjump: 10'd470};
    localparam speed_cfg_t CFG_8 = '{grav: 6'd60, duck_lim: 8'd16,  vjump: 10'd700};
endpackage

// File: rtl/player_vertical_ctrl_speed_params.sv
// speed_params: maps the game speed code to gravity, duck length and jump velocity
module speed_params
    import player_vertical_ctrl_pkg::*;
(
    input  logic [3:0] i_speed,
    output speed_cfg_t o_cfg
);
    assign o_cfg = i_speed == 4'd2 ? CFG_2 :
                   i_speed == 4'd4 ? CFG_4 :
                   i_speed == 4'd8 ? CFG_8 : CFG_1;
endmodule

// File: rtl/player_vertical_ctrl.sv
// player_vertical_ctrl: per-frame jump/duck physics for the runner player
module player_vertical_ctrl
    import player_vertical_ctrl_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       frame_in,
    input  logic [3:0] speed_in,
    input  logic       jump_in,
    input  logic       duck_in,
    output logic [9:0] height_out,
    output logic [1:0] state_out,
    output logic       ducking_out,
    output logic       airborne_out
);
    state_t       r_state, w_state;
    logic [15:0]  r_height, w_height;
    logic [11:0]  r_vel, w_vel;
    logic [7:0]   r_duck_cnt, w_duck_cnt;
    logic         r_duck_on_land, w_duck_on_land;
    logic         r_jump_pend, r_duck_pend;
    speed_cfg_t   r_cfg, w_cfg;
    logic         w_latch;
    logic         w_jump, w_duck, w_land;
    logic [17:0]  w_next;

    speed_params u_speed_params (.i_speed(speed_in), .o_cfg(w_cfg));

    assign w_jump = r_jump_pend | jump_in;
    assign w_duck = r_duck_pend | duck_in;
    assign w_next = {2'b00, r_height} + {{6{r_vel[11]}}, r_vel};
    assign w_land = r_vel[11] && (w_next[17] || w_next == 18'd0);

    always_comb begin
        w_state        = r_state;
        w_height       = r_height;
        w_vel          = r_vel;
        w_duck_cnt     = r_duck_cnt;
        w_duck_on_land = r_duck_on_land;
        w_latch        = 1'b0;
        case (r_state)
            GROUND, DUCK: begin
                if (w_jump) begin
                    w_state        = AIR;
                    w_height       = 16'd0;
                    w_vel          = {2'b00, w_cfg.vjump};
                    w_duck_on_land = 1'b0;
                    w_latch        = 1'b1;
                end else if (w_duck) begin
                    w_state    = DUCK;
                    w_duck_cnt = 8'd0;
                    w_latch    = r_state == GROUND;
                end else if (r_state == DUCK) begin
                    w_state    = r_duck_cnt == r_cfg.duck_lim - 8'd1 ? GROUND : DUCK;
                    w_duck_cnt = r_duck_cnt + 8'd1;
                end
            end
            AIR: begin
                if (w_land) begin
                    w_state        = r_duck_on_land ? DUCK : GROUND;
                    w_height       = 16'd0;
                    w_vel          = 12'd0;
                    w_duck_cnt     = 8'd0;
                    w_duck_on_land = 1'b0;
                end else begin
                    // a slam replaces this frame's gravity step
                    w_height       = w_next[15:0];
                    w_vel          = w_duck ? 12'd0 - {2'b00, r_cfg.vjump} : r_vel - {6'd0, r_cfg.grav};
                    w_duck_on_land = r_duck_on_land | w_duck;
                end
            end
            default: w_state = GROUND;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= GROUND;
            r_height       <= 16'd0;
            r_vel          <= 12'd0;
            r_duck_cnt     <= 8'd0;
            r_duck_on_land <= 1'b0;
            r_jump_pend    <= 1'b0;
            r_duck_pend    <= 1'b0;
            r_cfg          <= CFG_1;
        end else begin
            r_jump_pend <= !frame_in && (r_jump_pend | jump_in);
            r_duck_pend <= !frame_in && (r_duck_pend | duck_in);
            if (frame_in) begin
                r_state        <= w_state;
                r_height       <= w_height;
                r_vel          <= w_vel;
                r_duck_cnt     <= w_duck_cnt;
                r_duck_on_land <= w_duck_on_land;
                if (w_latch) r_cfg <= w_cfg;
            end
        end
    end

    assign height_out   = r_height[HEIGHT_SHIFT +: 10];
    assign state_out    = r_state;
    assign ducking_out  = r_state == DUCK;
    assign airborne_out = r_state == AIR;
endmodule

// File: tb/tb_player_vertical_ctrl.sv
// tb_player_vertical_ctrl: directed trajectory and duck-timing checks with hand-computed values
module tb_player_vertical_ctrl;
    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       frame_in = 1'b0;
    logic [3:0] speed_in = 4'd8;
    logic       jump_in = 1'b0;
    logic       duck_in = 1'b0;
    logic [9:0] height_out;
    logic [1:0] state_out;
    logic       ducking_out;
    logic       airborne_out;
    int         total = 0;
    int         bad = 0;
    int         n;

    player_vertical_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_in(frame_in), .speed_in(speed_in),
        .jump_in(jump_in), .duck_in(duck_in), .height_out(height_out),
        .state_out(state_out), .ducking_out(ducking_out), .airborne_out(airborne_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic frame(input logic j = 1'b0, input logic d = 1'b0);
        frame_in = 1'b1;
        jump_in  = j;
        duck_in  = d;
        step();
        frame_in = 1'b0;
        jump_in  = 1'b0;
        duck_in  = 1'b0;
        step();
    endtask

    task automatic frames(input int k);
        repeat (k) frame();
    endtask

    task automatic count_duck(output int cnt);
        cnt = ducking_out ? 1 : 0;
        for (int i = 0; i < 200 && ducking_out; i++) begin
            frame();
            if (ducking_out) cnt++;
        end
    endtask

    initial begin
        step();
        step();
        rst_in = 1'b0;
        chk("rst_height", height_out, 0);
        chk("rst_state", state_out, 0);
        chk("rst_duck", ducking_out, 0);
        chk("rst_air", airborne_out, 0);

        // speed 8 jump: 700, 640, ... peak 4440 at update 13, land on 26
        jump_in = 1'b1;
        step();
        jump_in = 1'b0;
        chk("pend_no_frame", state_out, 0);
        frame();
        chk("j8_u1_state", state_out, 1);
        chk("j8_u1_air", airborne_out, 1);
        chk("j8_u1_height", height_out, 0);
        frame();
        chk("j8_u2_height", height_out, 10);
        frames(11);
        chk("j8_u13_peak", height_out, 69);
        frames(12);
        chk("j8_u25_state", state_out, 1);
        chk("j8_u25_height", height_out, 3);
        frame();
        chk("j8_u26_state", state_out, 0);
        chk("j8_u26_height", height_out, 0);
        chk("j8_u26_air", airborne_out, 0);

        speed_in = 4'd4;
        frame(1'b0, 1'b1);
        chk("d4_state", state_out, 2);
        count_duck(n);
        chk("d4_frames", n, 32);
        chk("d4_end_state", state_out, 0);

        // slam at update 5: h 1920+520=2440, then -700, -760, -820, land on 9
        speed_in = 4'd8;
        frame(1'b1, 1'b0);
        frames(3);
        frame(1'b0, 1'b1);
        chk("slam_u5_height", height_out, 38);
        frame();
        chk("slam_u6_height", height_out, 27);
        frames(2);
        chk("slam_u8_height", height_out, 2);
        chk("slam_u8_state", state_out, 1);
        frame();
        chk("slam_land_state", state_out, 2);
        chk("slam_land_height", height_out, 0);
        count_duck(n);
        chk("slam_duck_frames", n, 16);
        chk("slam_end_state", state_out, 0);

        frame(1'b1, 1'b1);
        chk("both_state", state_out, 1);
        frames(8);
        frame(1'b1, 1'b0);
        frames(15);
        chk("dbl_u25_state", state_out, 1);
        frame();
        chk("dbl_u26_state", state_out, 0);

        // speed 1 latched: peak 16290 at update 181, h=180 after 361, land on 362
        speed_in = 4'd1;
        frame(1'b1, 1'b0);
        speed_in = 4'd8;
        frame();
        chk("s1_u2_height", height_out, 2);
        frames(179);
        chk("s1_peak", height_out, 254);
        frames(180);
        chk("s1_u361_state", state_out, 1);
        chk("s1_u361_height", height_out, 2);
        frame();
        chk("s1_land_state", state_out, 0);
        frame(1'b1, 1'b0);
        frame();
        chk("s8_u2_height", height_out, 10);
        frame();
        chk("s8_u3_height", height_out, 20);

        // unlisted code behaves as 1, then reset mid-air without a frame
        frames(30);
        speed_in = 4'd3;
        frame(1'b1, 1'b0);
        frame();
        chk("s3_u2_height", height_out, 2);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("rst_air_height", height_out, 0);
        chk("rst_air_state", state_out, 0);
        chk("rst_air_air", airborne_out, 0);
        rst_in  = 1'b1;
        jump_in = 1'b1;
        step();
        rst_in  = 1'b0;
        jump_in = 1'b0;
        frame();
        chk("rst_drop_jump", state_out, 0);
        frame(1'b0, 1'b1);
        chk("duck_again", ducking_out, 1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("rst_duck_out", ducking_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
